// File: rtl/bus_regfile.sv
// bus_regfile: memory-mapped register file for the 8-bit host bus.
// NUM_REGS general-purpose registers, a write-1-to-clear STATUS register of
// per-register dirty flags, a MASK register and a registered interrupt.
// Host strobes, address and data are asynchronous to clk and are synchronised
// before use. A falling edge of a synchronised strobe is one access.
module bus_regfile #(
    parameter logic [15:0] BASE_ADDRESS = 16'hA000,
    parameter int          NUM_REGS     = 4,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        write_strobe_b,
    input  logic        read_strobe_b,
    input  logic [15:0] address_bus,
    inout  wire  [7:0]  data_bus,
    output logic        bus_dir,
    output logic        irq
);

    localparam logic [15:0] STATUS_OFFSET = 16'(NUM_REGS);
    localparam logic [15:0] MASK_OFFSET   = 16'(NUM_REGS + 1);

    logic [SYNC_STAGES-1:0] wr_sync;
    logic [SYNC_STAGES-1:0] rd_sync;
    logic [15:0]            addr_sync [SYNC_STAGES];
    logic [7:0]             data_sync [SYNC_STAGES];
    logic [SYNC_STAGES:0]   valid_sr;
    logic                   wr_prev;
    logic                   rd_prev;

    logic                   wr_s;
    logic                   rd_s;
    logic [15:0]            addr_s;
    logic [7:0]             data_s;
    logic                   wr_event;
    logic                   rd_event;

    logic [15:0]            offset;
    logic                   is_gp;
    logic                   is_status;
    logic                   is_mask;
    logic                   mapped;
    logic [7:0]             rd_value;

    logic [7:0]             regs [NUM_REGS];
    logic [NUM_REGS-1:0]    dirty;
    logic [NUM_REGS-1:0]    mask;
    logic [7:0]             out_buf;

    // Synchronisers plus a validity shift register: strobe edges are ignored
    // until the chain holds real samples, so releasing reset with a strobe
    // already low does not look like a fresh access.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_sync  <= '1;
            rd_sync  <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                addr_sync[i] <= '0;
                data_sync[i] <= '0;
            end
            valid_sr <= '0;
            wr_prev  <= 1'b1;
            rd_prev  <= 1'b1;
        end else begin
            wr_sync      <= {wr_sync[SYNC_STAGES-2:0], write_strobe_b};
            rd_sync      <= {rd_sync[SYNC_STAGES-2:0], read_strobe_b};
            addr_sync[0] <= address_bus;
            data_sync[0] <= data_bus;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                addr_sync[i] <= addr_sync[i-1];
                data_sync[i] <= data_sync[i-1];
            end
            valid_sr <= {valid_sr[SYNC_STAGES-1:0], 1'b1};
            wr_prev  <= wr_sync[SYNC_STAGES-1];
            rd_prev  <= rd_sync[SYNC_STAGES-1];
        end
    end

    assign wr_s     = wr_sync[SYNC_STAGES-1];
    assign rd_s     = rd_sync[SYNC_STAGES-1];
    assign addr_s   = addr_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    // A simultaneous write wins; the read edge is simply dropped.
    assign wr_event = valid_sr[SYNC_STAGES] & wr_prev & ~wr_s;
    assign rd_event = valid_sr[SYNC_STAGES] & rd_prev & ~rd_s & ~wr_event;

    assign offset    = addr_s - BASE_ADDRESS;
    assign is_gp     = offset < STATUS_OFFSET;
    assign is_status = offset == STATUS_OFFSET;
    assign is_mask   = offset == MASK_OFFSET;
    assign mapped    = is_gp | is_status | is_mask;

    // Read multiplexer; unimplemented STATUS/MASK bits read as zero.
    always_comb begin
        rd_value = '0;
        if (is_gp) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (offset == 16'(i)) begin
                    rd_value = regs[i];
                end
            end
        end else if (is_status) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rd_value[i] = dirty[i];
            end
        end else if (is_mask) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rd_value[i] = mask[i];
            end
        end
    end

    // Register, dirty-flag and mask updates on a write event.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            dirty <= '0;
            mask  <= '0;
        end else if (wr_event) begin
            if (is_status) begin
                dirty <= dirty & ~data_s[NUM_REGS-1:0];
            end else if (is_mask) begin
                mask <= data_s[NUM_REGS-1:0];
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (offset == 16'(i)) begin
                        regs[i]  <= data_s;
                        dirty[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Read data capture and bus direction; a write during a read drops the drive.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            out_buf <= '0;
            bus_dir <= 1'b0;
        end else if (wr_event) begin
            bus_dir <= 1'b0;
        end else if (rd_event && mapped) begin
            out_buf <= rd_value;
            bus_dir <= 1'b1;
        end else if (rd_s) begin
            bus_dir <= 1'b0;
        end
    end

    // Interrupt follows the registered flags and mask one cycle later.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            irq <= 1'b0;
        end else begin
            irq <= |(dirty & mask);
        end
    end

    assign data_bus = bus_dir ? out_buf : 8'bz;

endmodule
